// File: rtl/phy_rx_pkg.sv
// Shared definitions for the PHY receive path: comma byte, widths, FSM encoding.
package phy_rx_pkg;

    localparam int unsigned BYTE_W      = 8;
    localparam int unsigned BIT_CNT_W   = 3;
    localparam int unsigned COMMA_CNT_W = 4;

    localparam logic [BYTE_W-1:0] COMMA_BYTE = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        SYNC   = 2'd2
    } rx_state_e;

endpackage : phy_rx_pkg

// File: rtl/byte_aligner.sv
// Bit-level front end of the deserializer: shift register, 8-bit sliding window,
// bit counter and the byte_done / comma_hit flags used by the receive FSM.
// Ports:
//   clk_i          bit clock
//   rst_i          asynchronous active-high reset
//   data_i         serial bit, sampled on posedge clk_i
//   cnt_clr_i      restart byte framing: bit counter loads 0 on this edge
//   window_c_o     {shift_q[6:0], data_i}, the byte ending at the current bit
//   byte_done_c_o  current edge samples the 8th bit of a framed byte
//   comma_hit_c_o  window equals the comma byte
module byte_aligner
    import phy_rx_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA = COMMA_BYTE
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              data_i,
    input  logic              cnt_clr_i,
    output logic [BYTE_W-1:0] window_c_o,
    output logic              byte_done_c_o,
    output logic              comma_hit_c_o
);

    logic [BYTE_W-1:0]    shift_q;
    logic [BYTE_W-1:0]    shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [BIT_CNT_W-1:0] bit_cnt_d;
    logic                 shift_msb_unused;

    // Window includes the bit being sampled so a byte is available on its 8th edge.
    assign window_c_o       = {shift_q[BYTE_W-2:0], data_i};
    assign byte_done_c_o    = (bit_cnt_q == BIT_CNT_W'(BYTE_W - 1));
    assign comma_hit_c_o    = (window_c_o == COMMA);
    assign shift_msb_unused = shift_q[BYTE_W-1];

    // Next-state: shift every edge, counter wraps 7->0 unless framing restarts.
    always_comb begin
        shift_d   = window_c_o;
        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
        if (cnt_clr_i) begin
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

endmodule : byte_aligner

// File: rtl/deserializador_sync_rx.sv
// Receive side of the PHY serial link: recovers MSB-first bytes from a 1-bit
// stream, aligns on commas and locks after SYNC_COUNT consecutive aligned commas.
// Ports:
//   clk_32f      bit clock
//   reset        asynchronous active-high reset
//   data_in      serial bit
//   data_out     last completed byte in SYNC, held between completions
//   valid_out    data_out is a non-comma byte (held for the byte period)
//   byte_strobe  one-cycle pulse per completed byte in SYNC
//   active       high while locked
module deserializador_sync_rx
    import phy_rx_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COMMA      = COMMA_BYTE,
    parameter int unsigned       SYNC_COUNT = 4
) (
    input  logic              clk_32f,
    input  logic              reset,
    input  logic              data_in,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              byte_strobe,
    output logic              active
);

    rx_state_e              state_q;
    rx_state_e              state_d;
    logic [COMMA_CNT_W-1:0] comma_cnt_q;
    logic [COMMA_CNT_W-1:0] comma_cnt_d;
    logic [BYTE_W-1:0]      data_out_q;
    logic [BYTE_W-1:0]      data_out_d;
    logic                   valid_q;
    logic                   valid_d;
    logic                   strobe_q;
    logic                   strobe_d;
    logic                   active_q;
    logic                   active_d;

    logic [BYTE_W-1:0]      window_c;
    logic                   byte_done_c;
    logic                   comma_hit_c;
    logic                   cnt_clr_c;
    logic [COMMA_CNT_W:0]   comma_inc_c;
    logic [COMMA_CNT_W-1:0] comma_sat_c;

    byte_aligner #(
        .COMMA (COMMA)
    ) u_byte_aligner (
        .clk_i         (clk_32f),
        .rst_i         (reset),
        .data_i        (data_in),
        .cnt_clr_i     (cnt_clr_c),
        .window_c_o    (window_c),
        .byte_done_c_o (byte_done_c),
        .comma_hit_c_o (comma_hit_c)
    );

    // Incremented comma count, clamped so it never wraps past SYNC_COUNT.
    always_comb begin
        comma_inc_c = (COMMA_CNT_W + 1)'(comma_cnt_q) + (COMMA_CNT_W + 1)'(1);
        comma_sat_c = comma_inc_c[COMMA_CNT_W-1:0];
        if (comma_inc_c >= (COMMA_CNT_W + 1)'(SYNC_COUNT)) begin
            comma_sat_c = COMMA_CNT_W'(SYNC_COUNT);
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        data_out_d  = data_out_q;
        valid_d     = valid_q;
        strobe_d    = 1'b0;
        active_d    = active_q;
        cnt_clr_c   = 1'b0;

        case (state_q)
            SEARCH: begin
                // Slide one bit at a time; a matching window fixes the byte framing.
                if (comma_hit_c) begin
                    cnt_clr_c   = 1'b1;
                    comma_cnt_d = COMMA_CNT_W'(1);
                    if (SYNC_COUNT == 1) begin
                        state_d  = SYNC;
                        active_d = 1'b1;
                    end else begin
                        state_d = ALIGN;
                    end
                end
            end
            ALIGN: begin
                if (byte_done_c) begin
                    if (comma_hit_c) begin
                        comma_cnt_d = comma_sat_c;
                        if (comma_inc_c == (COMMA_CNT_W + 1)'(SYNC_COUNT)) begin
                            state_d  = SYNC;
                            active_d = 1'b1;
                        end
                    end else begin
                        comma_cnt_d = '0;
                        state_d     = SEARCH;
                    end
                end
            end
            SYNC: begin
                // Framing is frozen: comma patterns across byte boundaries are plain data.
                active_d = 1'b1;
                if (byte_done_c) begin
                    data_out_d = window_c;
                    strobe_d   = 1'b1;
                    valid_d    = !comma_hit_c;
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f or posedge reset) begin
        if (reset) begin
            state_q     <= SEARCH;
            comma_cnt_q <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            strobe_q    <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            strobe_q    <= strobe_d;
            active_q    <= active_d;
        end
    end

    assign data_out    = data_out_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;

endmodule : deserializador_sync_rx

// File: tb/tb_deserializador_sync_rx.sv
// Directed self-checking bench for deserializador_sync_rx (COMMA=BC, SYNC_COUNT=4).
module tb_deserializador_sync_rx;

    logic       clk_32f = 1'b0;
    logic       reset   = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    deserializador_sync_rx dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    always #5 clk_32f = ~clk_32f;

    // Drive one bit on the falling edge; return 1 time unit after the sampling edge.
    task automatic send_bit(input logic b);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            send_bit(v[i]);
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk_32f);
        reset   = 1'b1;
        data_in = 1'b0;
        repeat (cycles) @(negedge clk_32f);
        reset = 1'b0;
    endtask

    // 1: reset held with a toggling stream keeps every output at zero.
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send_bit(i[0]);
        end
        total_cnt++;
        if ({data_out, valid_out, byte_strobe, active} !== 11'h000)
            $display("FAIL reset_outputs: got data=%h valid=%b strobe=%b active=%b, need all 0",
                     data_out, valid_out, byte_strobe, active);
        else pass_cnt++;
        @(negedge clk_32f);
        reset = 1'b0;
    endtask

    // All-zero then all-one streams never lock.
    task automatic test_idle_streams();
        for (int i = 0; i < 48; i++) begin
            send_bit(i >= 24);
            if (i % 8 == 7) begin
                total_cnt++;
                if ({data_out, valid_out, byte_strobe, active} !== 11'h000)
                    $display("FAIL idle_stream bit %0d: got data=%h valid=%b strobe=%b active=%b, need all 0",
                             i, data_out, valid_out, byte_strobe, active);
                else pass_cnt++;
            end
        end
    endtask

    // 2: four aligned commas; active rises exactly on the 32nd bit edge.
    task automatic test_lock_basic();
        logic [7:0] comma = 8'hBC;
        do_reset(2);
        for (int i = 0; i < 32; i++) begin
            send_bit(comma[7 - (i % 8)]);
            total_cnt++;
            if (active !== (i == 31) || valid_out !== 1'b0 || byte_strobe !== 1'b0)
                $display("FAIL lock_basic bit %0d: got active=%b valid=%b strobe=%b, need active=%b valid=0 strobe=0",
                         i + 1, active, valid_out, byte_strobe, (i == 31));
            else pass_cnt++;
        end
    endtask

    // 3: a non-comma during alignment drops back to SEARCH; four more commas lock.
    task automatic test_realign();
        logic [7:0] seq [8] = '{8'hBC, 8'hBC, 8'hBC, 8'h55, 8'hBC, 8'hBC, 8'hBC, 8'hBC};
        do_reset(2);
        for (int k = 0; k < 8; k++) begin
            send_byte(seq[k]);
            total_cnt++;
            if (active !== (k == 7) || valid_out !== 1'b0)
                $display("FAIL realign byte %0d: got active=%b valid=%b, need active=%b valid=0",
                         k, active, valid_out, (k == 7));
            else pass_cnt++;
        end
    endtask

    // 4: three garbage bits shift the framing; lock at that offset, then data is framed right.
    task automatic test_offset();
        do_reset(2);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC);
            total_cnt++;
            if (active !== (k == 3))
                $display("FAIL offset_lock comma %0d: got active=%b need %b", k, active, (k == 3));
            else pass_cnt++;
        end
        send_byte(8'hFC);
        total_cnt++;
        if (data_out !== 8'hFC || valid_out !== 1'b1 || byte_strobe !== 1'b1)
            $display("FAIL offset_data: got data=%h valid=%b strobe=%b, need data=fc valid=1 strobe=1",
                     data_out, valid_out, byte_strobe);
        else pass_cnt++;
    endtask

    // 5: stream in SYNC; strobe on every 8th edge, outputs held in between.
    task automatic test_sync_stream();
        logic [7:0] bytes [4] = '{8'hFC, 8'hFD, 8'hBC, 8'h12};
        logic       vals  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [7:0] prev_d = 8'hFC;
        logic       prev_v = 1'b1;
        logic [7:0] cur;
        for (int k = 0; k < 4; k++) begin
            cur = bytes[k];
            for (int i = 7; i >= 0; i--) begin
                send_bit(cur[i]);
                total_cnt++;
                if (i != 0) begin
                    if (byte_strobe !== 1'b0 || data_out !== prev_d || valid_out !== prev_v)
                        $display("FAIL sync_hold byte %0d bit %0d: got data=%h valid=%b strobe=%b, need data=%h valid=%b strobe=0",
                                 k, 7 - i, data_out, valid_out, byte_strobe, prev_d, prev_v);
                    else pass_cnt++;
                end else begin
                    if (byte_strobe !== 1'b1 || data_out !== cur || valid_out !== vals[k])
                        $display("FAIL sync_byte %0d: got data=%h valid=%b strobe=%b, need data=%h valid=%b strobe=1",
                                 k, data_out, valid_out, byte_strobe, cur, vals[k]);
                    else pass_cnt++;
                end
            end
            prev_d = cur;
            prev_v = vals[k];
        end
    endtask

    // Comma pattern straddling a byte boundary in SYNC is just data.
    task automatic test_no_realign();
        send_byte(8'h0B);
        total_cnt++;
        if (data_out !== 8'h0B || valid_out !== 1'b1 || active !== 1'b1)
            $display("FAIL no_realign_0b: got data=%h valid=%b active=%b, need 0b 1 1",
                     data_out, valid_out, active);
        else pass_cnt++;
        send_byte(8'hC0);
        total_cnt++;
        if (data_out !== 8'hC0 || valid_out !== 1'b1 || active !== 1'b1)
            $display("FAIL no_realign_c0: got data=%h valid=%b active=%b, need c0 1 1",
                     data_out, valid_out, active);
        else pass_cnt++;
    endtask

    // 6: asynchronous reset mid-byte in SYNC, then relock only after four fresh commas.
    task automatic test_reset_mid();
        logic [7:0] d = 8'hA5;
        for (int i = 7; i >= 4; i--) begin
            send_bit(d[i]);
        end
        #2;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({data_out, valid_out, byte_strobe, active} !== 11'h000)
            $display("FAIL async_reset: got data=%h valid=%b strobe=%b active=%b, need all 0",
                     data_out, valid_out, byte_strobe, active);
        else pass_cnt++;
        repeat (2) @(negedge clk_32f);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            send_byte(8'hBC);
            total_cnt++;
            if (active !== (k == 3) || valid_out !== 1'b0)
                $display("FAIL relock comma %0d: got active=%b valid=%b, need active=%b valid=0",
                         k, active, valid_out, (k == 3));
            else pass_cnt++;
        end
        send_byte(8'h12);
        total_cnt++;
        if (data_out !== 8'h12 || valid_out !== 1'b1)
            $display("FAIL relock_data: got data=%h valid=%b, need 12 1", data_out, valid_out);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_idle_streams();
        test_lock_basic();
        test_realign();
        test_offset();
        test_sync_stream();
        test_no_realign();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_deserializador_sync_rx
